// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_stall_ctrl_pkg;

   localparam int REG_W = 4;

   // Encoding loaded into ID/EX when a bubble is inserted (addi x0, x0, 0).
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_MEM_DONE = 2'd2,
      ST_ERR      = 2'd3
   } mem_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_sram_wait_fsm.sv
// SRAM access wait tracker: freezes the pipeline while an access is pending
// and latches a sticky error when the access never completes.
module sram_wait_fsm
#(
   parameter int MEM_TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_access,
   input  logic sram_ready,
   output logic mem_freeze,
   output logic mem_err
);
   import hazard_stall_ctrl_pkg::*;

   localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
   // The IDLE cycle that launches the access is itself a freeze cycle, so the
   // wait count gives up one step early to total MEM_TIMEOUT frozen cycles.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 2);

   mem_state_e        r_state;
   mem_state_e        w_state_next;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WAIT_W-1:0] w_wait_cnt_next;
   logic              r_mem_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_cnt_next;
         r_mem_err  <= r_mem_err | (w_state_next == ST_ERR);
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_wait_cnt_next = r_wait_cnt;
      mem_freeze      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (mem_access && !sram_ready) begin
               mem_freeze      = 1'b1;
               w_state_next    = ST_MEM_WAIT;
               w_wait_cnt_next = '0;
            end
         end
         ST_MEM_WAIT: begin
            w_wait_cnt_next = r_wait_cnt + 1'b1;
            if (sram_ready) begin
               w_state_next = ST_MEM_DONE;
            end else begin
               mem_freeze = 1'b1;
               if (r_wait_cnt == WAIT_LAST) begin
                  w_state_next = ST_ERR;
               end
            end
         end
         ST_MEM_DONE: begin
            w_state_next = ST_IDLE;
         end
         ST_ERR: begin
            mem_freeze = 1'b1;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign mem_err = r_mem_err;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: hazard stalls, branch flushes, SRAM freezes
// and a saturating stall-cycle counter for performance debug.
module hazard_stall_ctrl
#(
   parameter int REG_W       = hazard_stall_ctrl_pkg::REG_W,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             forward_en,
   input  logic             id_valid,
   input  logic [REG_W-1:0] src1,
   input  logic [REG_W-1:0] src2,
   input  logic             two_src,
   input  logic [REG_W-1:0] ex_dest,
   input  logic             ex_wb_en,
   input  logic             ex_mem_r_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   input  logic             mem_access,
   input  logic             sram_ready,
   input  logic             branch_taken,
   output logic             freeze_fe,
   output logic             bubble_ex,
   output logic             freeze_all,
   output logic             flush_fe,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_count
);
   import hazard_stall_ctrl_pkg::*;

   logic             w_hit_ex;
   logic             w_hit_mem;
   logic             w_haz;
   logic             w_mem_freeze;
   logic [CNT_W-1:0] r_stall_count;

   assign w_hit_ex  = (src1 == ex_dest)  || (two_src && (src2 == ex_dest));
   assign w_hit_mem = (src1 == mem_dest) || (two_src && (src2 == mem_dest));

   // With forwarding only a load in EX cannot be bypassed in time; without it
   // any pending write in EX or MEM must drain first.
   assign w_haz = id_valid &&
                  (forward_en ? (ex_wb_en && ex_mem_r_en && w_hit_ex)
                              : ((ex_wb_en && w_hit_ex) || (mem_wb_en && w_hit_mem)));

   sram_wait_fsm #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_sram_wait_fsm (
      .clk        (clk),
      .rst        (rst),
      .mem_access (mem_access),
      .sram_ready (sram_ready),
      .mem_freeze (w_mem_freeze),
      .mem_err    (mem_err)
   );

   // Freeze wins over everything; a taken branch discards ID so it beats the stall.
   always_comb begin
      freeze_fe = 1'b0;
      bubble_ex = 1'b0;
      flush_fe  = 1'b0;
      if (!w_mem_freeze) begin
         flush_fe  = branch_taken;
         bubble_ex = w_haz || branch_taken;
         freeze_fe = w_haz && !branch_taken;
      end
   end

   assign freeze_all = w_mem_freeze;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_count <= '0;
      end else if ((w_mem_freeze || freeze_fe) && (r_stall_count != '1)) begin
         r_stall_count <= r_stall_count + 1'b1;
      end
   end

   assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: vector table, corner sequences
// and randomized traffic against a behavioural model.
module tb_hazard_stall_ctrl;

   localparam int REG_W       = 4;
   localparam int CNT_W       = 5;
   localparam int MEM_TIMEOUT = 8;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             forward_en = 1'b0;
   logic             id_valid = 1'b0;
   logic [REG_W-1:0] src1 = '0;
   logic [REG_W-1:0] src2 = '0;
   logic             two_src = 1'b0;
   logic [REG_W-1:0] ex_dest = '0;
   logic             ex_wb_en = 1'b0;
   logic             ex_mem_r_en = 1'b0;
   logic [REG_W-1:0] mem_dest = '0;
   logic             mem_wb_en = 1'b0;
   logic             mem_access = 1'b0;
   logic             sram_ready = 1'b0;
   logic             branch_taken = 1'b0;
   logic             freeze_fe;
   logic             bubble_ex;
   logic             freeze_all;
   logic             flush_fe;
   logic             mem_err;
   logic [CNT_W-1:0] stall_count;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(
      .REG_W       (REG_W),
      .CNT_W       (CNT_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .forward_en   (forward_en),
      .id_valid     (id_valid),
      .src1         (src1),
      .src2         (src2),
      .two_src      (two_src),
      .ex_dest      (ex_dest),
      .ex_wb_en     (ex_wb_en),
      .ex_mem_r_en  (ex_mem_r_en),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .mem_access   (mem_access),
      .sram_ready   (sram_ready),
      .branch_taken (branch_taken),
      .freeze_fe    (freeze_fe),
      .bubble_ex    (bubble_ex),
      .freeze_all   (freeze_all),
      .flush_fe     (flush_fe),
      .mem_err      (mem_err),
      .stall_count  (stall_count)
   );

   typedef struct {
      logic             fwd, idv;
      logic [REG_W-1:0] s1, s2;
      logic             two;
      logic [REG_W-1:0] exd;
      logic             exwb, exld;
      logic [REG_W-1:0] memd;
      logic             memwb, acc, rdy, br;
      logic             e_ffe, e_bub, e_flush;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: access phase flags, frozen-cycle tally and stall total.
   bit m_dead, m_waiting, m_release;
   int m_frozen, m_count;
   bit e_ffe, e_bub, e_fall, e_flush;

   function automatic vec_t mk(int fwd, int idv, int s1, int s2, int two, int exd,
                               int exwb, int exld, int memd, int memwb, int acc,
                               int rdy, int br, int effe, int ebub, int eflush);
      vec_t v;
      v.fwd = fwd[0];  v.idv = idv[0];  v.s1 = REG_W'(s1);  v.s2 = REG_W'(s2);
      v.two = two[0];  v.exd = REG_W'(exd);  v.exwb = exwb[0];  v.exld = exld[0];
      v.memd = REG_W'(memd);  v.memwb = memwb[0];  v.acc = acc[0];  v.rdy = rdy[0];
      v.br = br[0];  v.e_ffe = effe[0];  v.e_bub = ebub[0];  v.e_flush = eflush[0];
      return v;
   endfunction

   task automatic apply(input vec_t v);
      forward_en = v.fwd;  id_valid = v.idv;  src1 = v.s1;  src2 = v.s2;
      two_src = v.two;  ex_dest = v.exd;  ex_wb_en = v.exwb;  ex_mem_r_en = v.exld;
      mem_dest = v.memd;  mem_wb_en = v.memwb;  mem_access = v.acc;
      sram_ready = v.rdy;  branch_taken = v.br;
   endtask

   function automatic bit reads(input logic [REG_W-1:0] r);
      return (src1 == r) || (two_src && (src2 == r));
   endfunction

   task automatic model_reset();
      m_dead = 0;  m_waiting = 0;  m_release = 0;  m_frozen = 0;  m_count = 0;
   endtask

   task automatic model_eval();
      bit haz;
      if (forward_en) haz = id_valid && ex_wb_en && ex_mem_r_en && reads(ex_dest);
      else haz = id_valid && ((ex_wb_en && reads(ex_dest)) || (mem_wb_en && reads(mem_dest)));
      e_fall = m_dead || (m_waiting && !sram_ready) ||
               (!m_dead && !m_waiting && !m_release && mem_access && !sram_ready);
      if (e_fall) begin
         e_ffe = 0;  e_bub = 0;  e_flush = 0;
      end else begin
         e_flush = branch_taken;
         e_bub   = haz || branch_taken;
         e_ffe   = haz && !branch_taken;
      end
   endtask

   task automatic model_clock();
      if ((e_fall || e_ffe) && m_count < CNT_MAX) m_count++;
      if (m_dead) begin
      end else if (m_release) begin
         m_release = 0;
      end else if (m_waiting) begin
         if (sram_ready) begin
            m_waiting = 0;  m_release = 1;
         end else begin
            m_frozen++;
            if (m_frozen == MEM_TIMEOUT) begin
               m_waiting = 0;  m_dead = 1;
            end
         end
      end else if (mem_access && !sram_ready) begin
         m_waiting = 1;  m_frozen = 1;
      end
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      model_eval();
      cmp({tag, ".freeze_fe"},   32'(freeze_fe),   32'(e_ffe));
      cmp({tag, ".bubble_ex"},   32'(bubble_ex),   32'(e_bub));
      cmp({tag, ".freeze_all"},  32'(freeze_all),  32'(e_fall));
      cmp({tag, ".flush_fe"},    32'(flush_fe),    32'(e_flush));
      cmp({tag, ".mem_err"},     32'(mem_err),     32'(m_dead));
      cmp({tag, ".stall_count"}, 32'(stall_count), 32'(m_count));
   endtask

   // Entered at a falling edge with inputs driven; leaves at the next falling edge.
   task automatic cycle(input string tag);
      #1;
      check_outputs(tag);
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      forward_en = 0;  id_valid = 0;  src1 = '0;  src2 = '0;  two_src = 0;
      ex_dest = '0;  ex_wb_en = 0;  ex_mem_r_en = 0;  mem_dest = '0;  mem_wb_en = 0;
      mem_access = 0;  sram_ready = 0;  branch_taken = 0;
   endtask

   // Asserts reset away from any clock edge and checks the cleared outputs at once.
   task automatic do_reset(input string tag);
      #2;
      rst = 1'b0;
      clear_inputs();
      model_reset();
      #1;
      check_outputs(tag);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   vec_t tbl[14];

   initial begin
      tbl[0]  = mk(1,1,3,0,0,3,1,1,0,0,0,0,0, 1,1,0);
      tbl[1]  = mk(1,1,3,0,0,3,1,0,0,0,0,0,0, 0,0,0);
      tbl[2]  = mk(1,1,3,0,0,7,1,1,3,1,0,0,0, 0,0,0);
      tbl[3]  = mk(0,1,1,5,1,9,1,0,5,1,0,0,0, 1,1,0);
      tbl[4]  = mk(0,1,1,5,0,9,1,0,5,1,0,0,0, 0,0,0);
      tbl[5]  = mk(0,1,4,0,0,4,1,0,0,0,0,0,0, 1,1,0);
      tbl[6]  = mk(0,1,4,0,0,4,0,0,0,0,0,0,0, 0,0,0);
      tbl[7]  = mk(1,0,3,0,0,3,1,1,0,0,0,0,0, 0,0,0);
      tbl[8]  = mk(1,1,3,0,0,3,1,1,0,0,0,0,1, 0,1,1);
      tbl[9]  = mk(1,1,2,2,1,9,1,1,9,1,0,0,1, 0,1,1);
      tbl[10] = mk(1,1,2,6,1,6,1,1,0,0,0,0,0, 1,1,0);
      tbl[11] = mk(1,1,2,6,0,6,1,1,0,0,0,0,0, 0,0,0);
      tbl[12] = mk(1,1,3,0,0,3,1,1,0,0,1,1,0, 1,1,0);
      tbl[13] = mk(0,1,5,0,0,9,1,0,5,0,0,0,0, 0,0,0);

      model_reset();
      @(negedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst = 1'b1;

      // Combinational hazard/priority table, pipeline otherwise idle.
      foreach (tbl[i]) begin
         apply(tbl[i]);
         #1;
         cmp($sformatf("vec%0d.freeze_fe", i), 32'(freeze_fe), 32'(tbl[i].e_ffe));
         cmp($sformatf("vec%0d.bubble_ex", i), 32'(bubble_ex), 32'(tbl[i].e_bub));
         cmp($sformatf("vec%0d.flush_fe", i),  32'(flush_fe),  32'(tbl[i].e_flush));
         $display("[TB] vec %0d: freeze_fe=%0d bubble_ex=%0d flush_fe=%0d freeze_all=%0d",
                  i, freeze_fe, bubble_ex, flush_fe, freeze_all);
         #1;
         cycle($sformatf("vec%0d", i));
      end

      // Load-use with forwarding: one stall, then the load sits in MEM.
      do_reset("rst_lu");
      apply(tbl[0]);
      #1;
      cmp("lu.count_before", 32'(stall_count), 32'd0);
      cycle("lu.stall");
      ex_wb_en = 0;  ex_mem_r_en = 0;  mem_dest = 4'd3;  mem_wb_en = 1;
      #1;
      cmp("lu.freeze_fe_after", 32'(freeze_fe), 32'd0);
      cmp("lu.count_after", 32'(stall_count), 32'd1);
      cycle("lu.release");
      $display("[TB] load-use sequence done, stall_count=%0d", stall_count);

      // SRAM wait: four frozen cycles, release, then a new access ignored in MEM_DONE.
      do_reset("rst_wait");
      mem_access = 1;  sram_ready = 0;
      repeat (4) cycle("wait.frozen");
      sram_ready = 1;
      cycle("wait.ready");
      sram_ready = 0;
      #1;
      cmp("wait.done_no_freeze", 32'(freeze_all), 32'd0);
      cycle("wait.done");
      mem_access = 0;  sram_ready = 1;
      cycle("wait.idle");
      #1;
      cmp("wait.count", 32'(stall_count), 32'd4);
      $display("[TB] sram wait sequence done, stall_count=%0d", stall_count);

      // Branch during freeze is held off until the access releases.
      do_reset("rst_br");
      apply(tbl[0]);
      branch_taken = 1;  mem_access = 1;  sram_ready = 0;
      repeat (3) cycle("br.frozen");
      sram_ready = 1;
      #1;
      cmp("br.release_flush", 32'(flush_fe), 32'd1);
      cmp("br.release_freeze_fe", 32'(freeze_fe), 32'd0);
      cycle("br.release");
      $display("[TB] branch-vs-freeze sequence done");

      // Asynchronous reset in the middle of a wait.
      do_reset("rst_mid0");
      mem_access = 1;  sram_ready = 0;
      repeat (4) cycle("mid.frozen");
      do_reset("mid.reset");
      $display("[TB] reset-mid-wait sequence done");

      // Timeout: error after MEM_TIMEOUT frozen cycles, absorbing, counter saturates.
      mem_access = 1;  sram_ready = 0;
      repeat (MEM_TIMEOUT) cycle("tmo.frozen");
      #1;
      cmp("tmo.mem_err", 32'(mem_err), 32'd1);
      mem_access = 0;  sram_ready = 1;  branch_taken = 1;
      repeat (30) cycle("tmo.hold");
      #1;
      cmp("tmo.saturated", 32'(stall_count), 32'(CNT_MAX));
      do_reset("tmo.reset");
      $display("[TB] timeout sequence done");

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0 || (mem_err && $urandom_range(0, 19) == 0)) begin
            do_reset("rnd.reset");
         end else begin
            forward_en   = 1'($urandom_range(0, 1));
            id_valid     = ($urandom_range(0, 9) < 8);
            src1         = REG_W'($urandom_range(0, 3));
            src2         = REG_W'($urandom_range(0, 3));
            two_src      = 1'($urandom_range(0, 1));
            ex_dest      = REG_W'($urandom_range(0, 3));
            ex_wb_en     = 1'($urandom_range(0, 1));
            ex_mem_r_en  = 1'($urandom_range(0, 1));
            mem_dest     = REG_W'($urandom_range(0, 3));
            mem_wb_en    = 1'($urandom_range(0, 1));
            mem_access   = ($urandom_range(0, 9) < 3);
            sram_ready   = ($urandom_range(0, 9) < 6);
            branch_taken = ($urandom_range(0, 9) < 2);
            cycle("rnd");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
